// File: rtl/param_counter.sv
// Up/down modulo counter with runtime limit and stride, sync clear/load, wrap or saturate.
// Optional bit-reversed output port enabled by defining BITREV_OUT_EN.
module param_counter #(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      STEP_W  = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic [WIDTH-1:0]  i_load_val,
  input  logic              i_dir,
  input  logic [STEP_W-1:0] i_step,
  input  logic [WIDTH-1:0]  i_limit,
  input  logic              i_sat,
  output logic [WIDTH-1:0]  o_count,
  output logic              o_max,
  output logic              o_min,
`ifdef BITREV_OUT_EN
  output logic              o_wrap,
  output logic [WIDTH-1:0]  o_count_rev
`else
  output logic              o_wrap
`endif
);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;

  logic [WIDTH:0]   w_count_x;
  logic [WIDTH:0]   w_limit_x;
  logic [WIDTH:0]   w_step_x;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_step_n;
  logic [WIDTH-1:0] w_up_wrap;
  logic [WIDTH-1:0] w_dn_wrap;
  logic [WIDTH-1:0] w_load_clip;
  logic [WIDTH-1:0] w_next;
  logic             w_wrap_next;

  // Bounds tests use WIDTH+1 bits; the wrap results only need the low WIDTH bits,
  // which modular arithmetic gives exactly, so i_limit = 2^WIDTH-1 still wraps cleanly.
  always_comb begin
    w_count_x   = {1'b0, r_count};
    w_limit_x   = {1'b0, i_limit};
    w_step_x    = (WIDTH+1)'(i_step);
    w_step_n    = WIDTH'(i_step);
    w_sum       = w_count_x + w_step_x;
    w_up_wrap   = r_count + w_step_n - i_limit - WIDTH'(1);
    w_dn_wrap   = r_count + i_limit + WIDTH'(1) - w_step_n;
    w_load_clip = (i_load_val > i_limit) ? i_limit : i_load_val;
  end

  always_comb begin
    w_next      = r_count;
    w_wrap_next = 1'b0;
    if (i_clr) begin
      w_next = '0;
    end else if (i_load) begin
      w_next = w_load_clip;
    end else if (i_en && (i_step != '0)) begin
      if (i_dir) begin
        if (w_sum <= w_limit_x) begin
          w_next = w_sum[WIDTH-1:0];
        end else if (i_sat) begin
          w_next = i_limit;
        end else begin
          w_next      = w_up_wrap;
          w_wrap_next = 1'b1;
        end
      end else begin
        if (w_count_x >= w_step_x) begin
          w_next = r_count - w_step_n;
        end else if (i_sat) begin
          w_next = '0;
        end else begin
          w_next      = w_dn_wrap;
          w_wrap_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= RST_VAL;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_next;
      r_wrap  <= w_wrap_next;
    end
  end

  assign o_count = r_count;
  assign o_wrap  = r_wrap;
  assign o_max   = (r_count >= i_limit);
  assign o_min   = (r_count == '0);

`ifdef BITREV_OUT_EN
  always_comb begin
    o_count_rev = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      o_count_rev[i] = r_count[WIDTH-1-i];
    end
  end
`endif

endmodule

// File: tb/tb_param_counter.sv
// Directed self-checking bench for param_counter (WIDTH=8, STEP_W=4, RST_VAL=0).
module tb_param_counter;

  logic       clk;
  logic       rst_n;
  logic       i_en;
  logic       i_clr;
  logic       i_load;
  logic [7:0] i_load_val;
  logic       i_dir;
  logic [3:0] i_step;
  logic [7:0] i_limit;
  logic       i_sat;
  logic [7:0] o_count;
  logic       o_max;
  logic       o_min;
  logic       o_wrap;
`ifdef BITREV_OUT_EN
  logic [7:0] o_count_rev;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  param_counter #(
    .WIDTH  (8),
    .STEP_W (4),
    .RST_VAL(8'd0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (i_en),
    .i_clr      (i_clr),
    .i_load     (i_load),
    .i_load_val (i_load_val),
    .i_dir      (i_dir),
    .i_step     (i_step),
    .i_limit    (i_limit),
    .i_sat      (i_sat),
    .o_count    (o_count),
    .o_max      (o_max),
    .o_min      (o_min),
`ifdef BITREV_OUT_EN
    .o_wrap     (o_wrap),
    .o_count_rev(o_count_rev)
`else
    .o_wrap     (o_wrap)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input logic [7:0] c, input logic w);
    check({tag, "_count"}, {24'd0, o_count}, {24'd0, c});
    check({tag, "_wrap"},  {31'd0, o_wrap},  {31'd0, w});
  endtask

  task automatic load(input logic [7:0] v);
    i_load = 1'b1; i_load_val = v;
    tick();
    i_load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; i_en = 1'b0; i_clr = 1'b0; i_load = 1'b0; i_load_val = '0;
    i_dir = 1'b1; i_step = 4'd1; i_limit = 8'd255; i_sat = 1'b0;
    #12;
    chk_cnt("rst_hold", 8'h00, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_cnt("rst_idle", 8'h00, 1'b0);
    check("rst_min", {31'd0, o_min}, 32'd1);

    // asynchronous reset mid-count, no clock edge
    load(8'h37);
    chk_cnt("pre_rst", 8'h37, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_cnt("async_rst", 8'h00, 1'b0);
    #1 rst_n = 1'b1;
    tick();

    // wrap up: limit 9, step 3
    i_limit = 8'd9; i_step = 4'd3; i_dir = 1'b1; i_sat = 1'b0; i_en = 1'b1;
    tick(); chk_cnt("wu1", 8'd3, 1'b0); check("wu1_max", {31'd0, o_max}, 32'd0);
    tick(); chk_cnt("wu2", 8'd6, 1'b0);
    tick(); chk_cnt("wu3", 8'd9, 1'b0); check("wu3_max", {31'd0, o_max}, 32'd1);
    tick(); chk_cnt("wu4", 8'd2, 1'b1); check("wu4_max", {31'd0, o_max}, 32'd0);
    tick(); chk_cnt("wu5", 8'd5, 1'b0);
    i_en = 1'b0;
    tick(); chk_cnt("idle_hold", 8'd5, 1'b0);

    // saturate up then down
    load(8'd8);
    i_step = 4'd4; i_sat = 1'b1; i_en = 1'b1;
    tick(); chk_cnt("su1", 8'd9, 1'b0);
    tick(); chk_cnt("su2", 8'd9, 1'b0);
    tick(); chk_cnt("su3", 8'd9, 1'b0);
    i_dir = 1'b0;
    tick(); chk_cnt("sd1", 8'd5, 1'b0);
    tick(); chk_cnt("sd2", 8'd1, 1'b0);
    tick(); chk_cnt("sd3", 8'd0, 1'b0);
    tick(); chk_cnt("sd4", 8'd0, 1'b0); check("sd4_min", {31'd0, o_min}, 32'd1);

    // down wrap: limit 15, step 1 from 0
    i_en = 1'b0; i_limit = 8'd15; i_step = 4'd1; i_sat = 1'b0;
    #1 check("dw_min_before", {31'd0, o_min}, 32'd1);
    i_en = 1'b1;
    tick(); chk_cnt("dw", 8'd15, 1'b1); check("dw_min_after", {31'd0, o_min}, 32'd0);
    i_en = 1'b0;
    tick(); chk_cnt("dw_after", 8'd15, 1'b0);

    // down wrap with stride: 1 + 10 - 3 = 8
    i_limit = 8'd9; load(8'd1);
    i_step = 4'd3; i_en = 1'b1;
    tick(); chk_cnt("dws", 8'd8, 1'b1);
    i_en = 1'b0;

    // priority
    load(8'd5);
    i_clr = 1'b1; i_load = 1'b1; i_load_val = 8'd7; i_en = 1'b1; i_dir = 1'b1;
    tick(); chk_cnt("pri_clr", 8'd0, 1'b0);
    i_clr = 1'b0; i_limit = 8'd99; i_load_val = 8'd200;
    tick(); chk_cnt("pri_load_clip", 8'd99, 1'b0); check("clip_max", {31'd0, o_max}, 32'd1);
    i_load = 1'b0; i_en = 1'b0;

    // full range wrap
    i_limit = 8'd255; load(8'd255);
    i_step = 4'd1; i_dir = 1'b1; i_sat = 1'b0; i_en = 1'b1;
    tick(); chk_cnt("full", 8'd0, 1'b1); check("full_min", {31'd0, o_min}, 32'd1);

    // step 0 holds
    i_step = 4'd0;
    tick(); chk_cnt("step0", 8'd0, 1'b0);
    i_en = 1'b0;

    // back-to-back wraps: limit 3, step 3
    i_limit = 8'd3; i_step = 4'd3; i_en = 1'b1;
    tick(); chk_cnt("bb1", 8'd3, 1'b0);
    tick(); chk_cnt("bb2", 8'd2, 1'b1);
    tick(); chk_cnt("bb3", 8'd1, 1'b1);
    i_en = 1'b0;

    // limit lowered below count: up is overflow, down is plain subtract
    i_limit = 8'd255; load(8'd50);
    i_limit = 8'd20; i_step = 4'd1; i_dir = 1'b1; i_en = 1'b1;
    tick(); chk_cnt("low_up", 8'd30, 1'b1); check("low_max", {31'd0, o_max}, 32'd1);
    i_en = 1'b0; i_limit = 8'd255; load(8'd50); i_limit = 8'd20;
    i_dir = 1'b0; i_step = 4'd5; i_en = 1'b1;
    tick(); chk_cnt("low_dn", 8'd45, 1'b0);
    i_en = 1'b0;

`ifdef BITREV_OUT_EN
    i_limit = 8'd255; load(8'h01);
    check("bitrev", {24'd0, o_count_rev}, 32'h80);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
